// File: rtl/io_pkg.sv
// Shared constants and the seven-segment hex encoder
// for the board-side display and switch controller.
package io_pkg;

  localparam int unsigned IO_ADDR  = 4096;
  localparam int unsigned N_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // gfedcba, active-low
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser and 3-sample debouncer sharing one
// sample prescaler; pulses sw_event when any output bit flips.
module sw_debounce
  import io_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DB_DIV = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] ioin,
  output logic             sw_event
);

  localparam int DW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DB_DIV - 1);

  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [WIDTH-1:0]       s1_q, s2_q;
  logic [WIDTH-1:0][2:0]  hist_q, hist_d;
  logic [WIDTH-1:0]       ioin_q, ioin_d;
  logic                   ev_q;
  logic                   tick;

  assign tick = (dcnt_q == DLAST);

  always_comb begin
    dcnt_d = tick ? '0 : dcnt_q + 1'b1;
    hist_d = hist_q;
    ioin_d = ioin_q;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        hist_d[i] = {hist_q[i][1:0], s2_q[i]};
        if (hist_d[i] == 3'b111)
          ioin_d[i] = 1'b1;
        else if (hist_d[i] == 3'b000)
          ioin_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      dcnt_q <= '0;
      hist_q <= '0;
      ioin_q <= '0;
      ev_q   <= 1'b0;
    end else begin
      s1_q   <= sw_raw;
      s2_q   <= s1_q;
      dcnt_q <= dcnt_d;
      hist_q <= hist_d;
      ioin_q <= ioin_d;
      ev_q   <= (ioin_d != ioin_q);
    end
  end

  assign ioin     = ioin_q;
  assign sw_event = ev_q;

endmodule

// File: rtl/io_display_ctrl.sv
// Memory-mapped I/O board controller: 4-digit multiplexed hex
// display of ioout plus debounced switches returned on ioin.
module io_display_ctrl
  import io_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DB_DIV      = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         ioout,
  input  logic [15:0]         sw_raw,
  output logic [15:0]         ioin,
  output logic                sw_event,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CLAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         snap_q, snap_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (cnt_q == CLAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    // Latch a whole frame at once so digits never tear
    if (cnt_q == '0 && idx_q == 2'd0)
      snap_d = ioout;
    an_d  = ~(N_DIGITS'(1) << idx_q);
    seg_d = hex7seg(snap_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

  sw_debounce #(
    .WIDTH  (16),
    .DB_DIV (DB_DIV)
  ) u_sw_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .ioin     (ioin),
    .sw_event (sw_event)
  );

endmodule
